// File: rtl/muldiv_if.sv
// Bundles the EX-stage request and result signals of the HI/LO multiply/divide unit.
// The pipeline drives the master modport and the unit implements the slave modport.
interface muldiv_if;
  logic        issue;
  logic        is_mult;
  logic        is_multu;
  logic        is_div;
  logic        is_divu;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_wen;
  logic        lo_wen;
  logic        rd_hilo;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  modport master (
    output issue, is_mult, is_multu, is_div, is_divu,
    output rs_data, rt_data, hi_wen, lo_wen, rd_hilo, flush,
    input  hi, lo, busy, stall
  );

  modport slave (
    input  issue, is_mult, is_multu, is_div, is_divu,
    input  rs_data, rt_data, hi_wen, lo_wen, rd_hilo, flush,
    output hi, lo, busy, stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply, 32-step restoring divide, one-cycle sign fix.
// Optional build macro MULDIV_FAST_MULT_EN replaces the iterative multiply with a single-cycle multiplier.
module muldiv_unit (
  input  logic     clk,
  input  logic     resetn,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [31:0] operand_b;
  logic [4:0]  count;
  logic        op_div;
  logic        res_neg;
  logic        rem_neg;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        sel_mult;
  logic        sel_multu;
  logic        sel_div;
  logic        sel_divu;
  logic        sel_signed;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic        div_zero;
  logic        start_ok;
  logic        start_div;
  logic        start_mul;

  logic [32:0] mul_sum;
  logic [32:0] div_top;
  logic [32:0] div_diff;
  logic [63:0] prod_fixed;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Op decode with mult > multu > div > divu priority; signed ops work on magnitudes.
  always_comb begin
    sel_mult   = bus.is_mult;
    sel_multu  = ~bus.is_mult & bus.is_multu;
    sel_div    = ~bus.is_mult & ~bus.is_multu & bus.is_div;
    sel_divu   = ~bus.is_mult & ~bus.is_multu & ~bus.is_div & bus.is_divu;
    sel_signed = sel_mult | sel_div;
    rs_neg     = sel_signed & bus.rs_data[31];
    rt_neg     = sel_signed & bus.rt_data[31];
    rs_mag     = rs_neg ? (32'd0 - bus.rs_data) : bus.rs_data;
    rt_mag     = rt_neg ? (32'd0 - bus.rt_data) : bus.rt_data;
    div_zero   = (sel_div | sel_divu) & (bus.rt_data == 32'd0);
    start_ok   = bus.issue & ~bus.flush & (state == IDLE);
    start_div  = start_ok & (sel_div | sel_divu) & ~div_zero;
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_product;

  assign start_mul    = 1'b0;
  assign fast_product = {{32{sel_mult & bus.rs_data[31]}}, bus.rs_data}
                      * {{32{sel_mult & bus.rt_data[31]}}, bus.rt_data};
`else
  assign start_mul = start_ok & (sel_mult | sel_multu);
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_div)      state_next = DIV;
        else if (start_mul) state_next = MUL;
      end
      MUL, DIV: begin
        if (count == 5'd31) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // One step per cycle: multiply shifts the accumulator right, divide shifts it left.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, operand_b};
    div_top  = {acc[63:32], acc[31]};
    div_diff = div_top - {1'b0, operand_b};
    acc_next = acc;
    case (state)
      MUL: begin
        if (acc[0]) acc_next = {mul_sum, acc[31:1]};
        else        acc_next = {1'b0, acc[63:32], acc[31:1]};
      end
      DIV: begin
        if (!div_diff[32]) acc_next = {div_diff[31:0], acc[30:0], 1'b1};
        else               acc_next = {div_top[31:0], acc[30:0], 1'b0};
      end
      default: acc_next = acc;
    endcase
  end

  always_comb begin
    prod_fixed = res_neg ? (64'd0 - acc) : acc;
    quot_fixed = res_neg ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fixed  = rem_neg ? (32'd0 - acc[63:32]) : acc[63:32];
    fix_hi     = op_div ? rem_fixed : prod_fixed[63:32];
    fix_lo     = op_div ? quot_fixed : prod_fixed[31:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      acc       <= 64'd0;
      operand_b <= 32'd0;
      count     <= 5'd0;
      op_div    <= 1'b0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          count <= 5'd0;
          if (bus.hi_wen) hi_q <= bus.rs_data;
          if (bus.lo_wen) lo_q <= bus.rs_data;
          if (start_div || start_mul) begin
            acc       <= {32'd0, start_div ? rs_mag : rt_mag};
            operand_b <= start_div ? rt_mag : rs_mag;
            op_div    <= start_div;
            res_neg   <= rs_neg ^ rt_neg;
            rem_neg   <= rs_neg;
          end
`ifdef MULDIV_FAST_MULT_EN
          if (start_ok && (sel_mult || sel_multu)) begin
            hi_q <= fast_product[63:32];
            lo_q <= fast_product[31:0];
          end
`endif
        end
        MUL, DIV: begin
          acc   <= acc_next;
          count <= count + 5'd1;
        end
        FIX: begin
          // A flush in the fix cycle cancels the write-back.
          if (!bus.flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: count <= 5'd0;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & (bus.rd_hilo | bus.issue | bus.hi_wen | bus.lo_wen);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic HI/LO model.
// Honors MULDIV_FAST_MULT_EN for the expected multiply latency.
module tb_muldiv_unit;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Reference model: architectural HI/LO result and busy duration of one op (0 mult,1 multu,2 div,3 divu).
  task automatic modelOp(input int op, input logic [31:0] a, input logic [31:0] b, output int lat);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 33;
    case (op)
      0, 1: begin
        if (op == 0) p = 64'(sa * sb);
        else         p = {32'd0, a} * {32'd0, b};
        model_hi = p[63:32];
        model_lo = p[31:0];
`ifdef MULDIV_FAST_MULT_EN
        lat = 0;
`endif
      end
      2: begin
        if (b == 32'd0) lat = 0;
        else begin
          sq = sa / sb;
          sr = sa % sb;
          model_lo = sq[31:0];
          model_hi = sr[31:0];
        end
      end
      default: begin
        if (b == 32'd0) lat = 0;
        else begin
          model_lo = a / b;
          model_hi = a % b;
        end
      end
    endcase
  endtask

  task automatic setStrobes(input int op);
    bus.is_mult  = (op == 0);
    bus.is_multu = (op == 1);
    bus.is_div   = (op == 2);
    bus.is_divu  = (op == 3);
  endtask

  task automatic applyStimulus(input int op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    int lat;
    @(negedge clk);
    bus.rs_data = a;
    bus.rt_data = b;
    bus.issue   = 1'b1;
    setStrobes(op);
    @(negedge clk);
    bus.issue   = 1'b0;
    setStrobes(-1);
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      if (n == 3) begin
        // A second op presented while busy must stall and be dropped.
        bus.issue = 1'b1;
        setStrobes(0);
        #1 checkOutput({tag, "_stall_issue"}, 64'(bus.stall), 64'd1);
      end else if (n == 4) begin
        bus.issue = 1'b0;
        setStrobes(-1);
      end
      @(negedge clk);
    end
    bus.issue = 1'b0;
    setStrobes(-1);
    modelOp(op, a, b, lat);
    checkOutput({tag, "_latency"}, 64'(n), 64'(lat));
    checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(model_hi));
    checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(model_lo));
  endtask

  task automatic writeHiLo(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    bus.rs_data = d;
    bus.hi_wen  = hw;
    bus.lo_wen  = lw;
    @(negedge clk);
    bus.hi_wen = 1'b0;
    bus.lo_wen = 1'b0;
    if (hw) model_hi = d;
    if (lw) model_lo = d;
    checkOutput("mthilo_hi", 64'(bus.hi), 64'(model_hi));
    checkOutput("mthilo_lo", 64'(bus.lo), 64'(model_lo));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          op;
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    checks      = 0;
    errors      = 0;
    model_hi    = 32'd0;
    model_lo    = 32'd0;
    resetn      = 1'b0;
    bus.issue   = 1'b0;
    setStrobes(-1);
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    bus.hi_wen  = 1'b0;
    bus.lo_wen  = 1'b0;
    bus.rd_hilo = 1'b0;
    bus.flush   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_stall", 64'(bus.stall), 64'd0);
    resetn = 1'b1;

    applyStimulus(3, 32'd100, 32'd7, "divu_100_7");
    checkOutput("divu_100_7_lo_const", 64'(bus.lo), 64'd14);
    checkOutput("divu_100_7_hi_const", 64'(bus.hi), 64'd2);
    applyStimulus(2, 32'hFFFF_FF9C, 32'd7, "div_m100_7");
    checkOutput("div_m100_7_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFF2);
    checkOutput("div_m100_7_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    applyStimulus(2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checkOutput("div_ovf_lo_const", 64'(bus.lo), 64'h0000_0000_8000_0000);
    checkOutput("div_ovf_hi_const", 64'(bus.hi), 64'd0);
    applyStimulus(0, 32'hFFFF_FFFF, 32'd2, "mult_m1_2");
    checkOutput("mult_m1_2_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    checkOutput("mult_m1_2_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);
    applyStimulus(1, 32'hFFFF_FFFF, 32'd2, "multu_m1_2");
    checkOutput("multu_m1_2_hi_const", 64'(bus.hi), 64'd1);
    checkOutput("multu_m1_2_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);
    applyStimulus(3, 32'h1234_5678, 32'd0, "divu_zero");
    applyStimulus(2, 32'h8765_4321, 32'd0, "div_zero");
    writeHiLo(1'b1, 1'b0, 32'h1234_5678);
    checkOutput("mthi_const", 64'(bus.hi), 64'h0000_0000_1234_5678);
    writeHiLo(1'b0, 1'b1, 32'hCAFE_F00D);

    // Stall on mfhi/mflo while busy, then flush cancels the divide.
    @(negedge clk);
    bus.rs_data = 32'd1000;
    bus.rt_data = 32'd3;
    bus.issue   = 1'b1;
    setStrobes(3);
    @(negedge clk);
    bus.issue = 1'b0;
    setStrobes(-1);
    #1 checkOutput("busy_no_req_stall", 64'(bus.stall), 64'd0);
    repeat (4) @(negedge clk);
    bus.rd_hilo = 1'b1;
    #1 checkOutput("rd_hilo_stall", 64'(bus.stall), 64'd1);
    repeat (5) @(negedge clk);
    checkOutput("rd_hilo_stall_held", 64'(bus.stall), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_busy", 64'(bus.busy), 64'd0);
    checkOutput("flush_stall", 64'(bus.stall), 64'd0);
    checkOutput("flush_hi", 64'(bus.hi), 64'(model_hi));
    checkOutput("flush_lo", 64'(bus.lo), 64'(model_lo));
    bus.rd_hilo = 1'b0;

    // Flush coinciding with issue drops the op.
    @(negedge clk);
    bus.rs_data = 32'd50;
    bus.rt_data = 32'd5;
    bus.issue   = 1'b1;
    bus.flush   = 1'b1;
    setStrobes(3);
    @(negedge clk);
    bus.issue = 1'b0;
    bus.flush = 1'b0;
    setStrobes(-1);
    checkOutput("flush_issue_busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 5));
      a   = $urandom;
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      if (sel == 2) a = 32'h8000_0000;
      applyStimulus(op, a, b, $sformatf("rand%0d_op%0d", i, op));
      if (sel == 3) writeHiLo(1'($urandom_range(0, 1)), 1'b1, $urandom);
    end

    // Asynchronous reset in the middle of a divide.
    writeHiLo(1'b1, 1'b1, 32'h5A5A_A5A5);
    @(negedge clk);
    bus.rs_data = $urandom;
    bus.rt_data = 32'd9;
    bus.issue   = 1'b1;
    setStrobes(2);
    @(negedge clk);
    bus.issue = 1'b0;
    setStrobes(-1);
    bus.rd_hilo = 1'b1;
    repeat (19) @(negedge clk);
    checkOutput("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("async_reset_lo", 64'(bus.lo), 64'd0);
    checkOutput("async_reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("async_reset_stall", 64'(bus.stall), 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    bus.rd_hilo = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(3, 32'd100, 32'd7, "post_reset_divu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  sole clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- issue  in  1  EX-stage op valid; qualifies the four op strobes.
- is_mult, is_multu, is_div, is_divu  in  1 each  op select from decode.
- rs_data, rt_data  in  32 each  operands; rs = multiplicand/dividend, rt = multiplier/divisor.
- hi_wen, lo_wen  in  1 each  mthi/mtlo write strobes; data is rs_data.
- rd_hilo  in  1  EX holds mfhi/mflo this cycle.
- flush  in  1  exception/eret cancel.
- hi, lo  out  32 each  architectural HI/LO registers.
- busy  out  1  operation in flight.
- stall  out  1  pipeline hold request.
REQ-002 SHALL drive stall = busy & (rd_hilo | issue | hi_wen | lo_wen), combinationally.

Function
REQ-003 SHALL use states IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-004 SHALL leave IDLE only when issue is high, flush is low and an op strobe is set; strobe priority is mult > multu > div > divu.
REQ-005 SHALL latch operand magnitudes (signed ops: two's-complement absolute value), a result-negate flag (sign(rs) XOR sign(rt)) and a remainder-negate flag (sign(rs)) on the issue edge.
REQ-006 In DIV, SHALL perform restoring division, one quotient bit per cycle, for exactly 32 cycles, then enter FIX.
REQ-007 In MUL, SHALL perform shift-add, one multiplier bit per cycle, for exactly 32 cycles, into a 64-bit accumulator, then enter FIX.
REQ-008 In FIX (1 cycle), SHALL apply the sign corrections, write HI/LO on the FIX->IDLE edge, and return to IDLE.
- mult: {HI,LO} = 64-bit product.
- div: LO = quotient, HI = remainder.
REQ-009 Latency: busy high for 33 cycles after the issue edge; new HI/LO visible in the first cycle busy is low.
REQ-010 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-011 Divisor zero (div or divu) SHALL stay in IDLE, leave HI/LO unchanged and never assert busy.
REQ-012 flush SHALL return any state to IDLE on the next edge with HI/LO unchanged; if flush coincides with issue, issue is ignored.
REQ-013 hi_wen/lo_wen in IDLE SHALL write rs_data to HI/LO on that edge; while busy they are ignored (stall holds them upstream).
REQ-014 issue while busy SHALL be ignored; the op is re-presented after stall drops.
REQ-015 Operands SHALL be taken only at issue; later rs_data/rt_data changes have no effect.

Reset
REQ-016 resetn low SHALL immediately force state IDLE, hi=0, lo=0, busy=0, stall=0, and clear the accumulator, counter and flags.
REQ-017 Reset asserted mid-operation SHALL abort the operation; no partial result reaches HI/LO.

Configuration
REQ-018 Macro MULDIV_FAST_MULT_EN:
- Defined: mult/multu use a single-cycle 32x32 multiplier and write HI/LO on the issue edge; MUL state unused; busy never asserts for multiply.
- Undefined: multiply is iterative per REQ-007/REQ-009.
- Division behaviour is identical in both builds.

Verification
REQ-019 divu rs=100, rt=7 -> busy for 33 cycles, then LO=14, HI=2.
REQ-020 div rs=0xFFFFFF9C (-100), rt=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2); also 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-021 mult rs=0xFFFFFFFF, rt=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with same operands -> HI=1, LO=0xFFFFFFFE. Check 33-cycle latency without the macro, 0-cycle with it.
REQ-022 Start divu, assert rd_hilo at cycle 5 -> stall=1 until busy falls; flush at cycle 10 -> IDLE next cycle, HI/LO keep prior values.
REQ-023 divu rt=0 -> busy never rises, HI/LO unchanged; mthi rs=0x12345678 in IDLE -> HI=0x12345678 the next cycle.
REQ-024 resetn pulsed low at cycle 20 of a div -> hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
